// File: rtl/vector_processor.sv
// Four-lane 8.8 fixed-point vector unit answering the shader start/done handshake.
// One shared 17x17 signed multiplier serves all lanes; LENGTH finishes with a bitwise restoring sqrt.
module vector_processor #(
    parameter int DATA_WIDTH   = 16,
    parameter int VECTOR_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [3:0]                           operation,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vec_a,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vec_b,
    input  logic [DATA_WIDTH-1:0]                scalar,
    output logic                                 busy,
    output logic                                 done,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   result,
    output logic                                 result_valid
);
    typedef enum logic [1:0] {IDLE, LANE, SQRT, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DOT = 4'd3,
                           OP_SCALE = 4'd4, OP_LENGTH = 4'd5;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [3:0]  iter_q, iter_d;
    logic [63:0] a_q, b_q;
    logic [15:0] s_q;
    logic [3:0]  op_q;
    logic [63:0] wres_q, wres_d, result_q, result_d;
    logic [33:0] acc_q, acc_d;
    logic [31:0] rad_q, rad_d;
    logic [19:0] rem_q, rem_d;
    logic [15:0] root_q, root_d;

    function automatic logic [15:0] lane_of(input logic [63:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[63:48];
            2'd1:    return v[47:32];
            2'd2:    return v[31:16];
            default: return v[15:0];
        endcase
    endfunction

    function automatic logic [63:0] put_lane(input logic [63:0] v, input logic [1:0] i,
                                             input logic [15:0] x);
        logic [63:0] r;
        r = v;
        case (i)
            2'd0:    r[63:48] = x;
            2'd1:    r[47:32] = x;
            2'd2:    r[31:16] = x;
            default: r[15:0]  = x;
        endcase
        return r;
    endfunction

    // In IDLE the raw inputs feed the datapath so lane 0 is processed on the accept edge.
    logic               idle;
    logic [3:0]         cur_op;
    logic [63:0]        cur_a, cur_b;
    logic [15:0]        cur_s, mul_x, mul_y;
    logic [1:0]         cur_lane;
    logic               mul_signed, lane_op;
    logic signed [16:0] mx, my;
    logic signed [33:0] prod;
    logic [33:0]        acc_next;
    logic [63:0]        alu_res;
    logic [19:0]        rem_sh, trial;
    logic [15:0]        root_n;

    always_comb begin
        idle       = (state_q == IDLE);
        cur_op     = idle ? operation : op_q;
        cur_a      = idle ? vec_a : a_q;
        cur_b      = idle ? vec_b : b_q;
        cur_s      = idle ? scalar : s_q;
        cur_lane   = idle ? 2'd0 : lane_q;
        mul_signed = (cur_op == OP_DOT) || (cur_op == OP_LENGTH);
        lane_op    = (cur_op >= OP_MUL) && (cur_op <= OP_LENGTH);
        mul_x      = lane_of(cur_a, cur_lane);
        mul_y      = (cur_op == OP_SCALE)  ? cur_s :
                     (cur_op == OP_LENGTH) ? mul_x : lane_of(cur_b, cur_lane);
        mx         = $signed({mul_signed & mul_x[15], mul_x});
        my         = $signed({mul_signed & mul_y[15], mul_y});
        prod       = mx * my;
        acc_next   = (idle ? 34'd0 : acc_q) + prod;

        alu_res = '0;
        for (int i = 0; i < 4; i++) begin
            if (cur_op == OP_ADD)
                alu_res[i*16 +: 16] = cur_a[i*16 +: 16] + cur_b[i*16 +: 16];
            else if (cur_op == OP_SUB)
                alu_res[i*16 +: 16] = cur_a[i*16 +: 16] - cur_b[i*16 +: 16];
        end

        // One restoring step: bring down two radicand bits, try appending a 1 to the root.
        rem_sh = (rem_q << 2) | {18'd0, rad_q[31:30]};
        trial  = {2'b00, root_q, 2'b01};
        root_n = {root_q[14:0], (rem_sh >= trial)};
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        iter_d   = iter_q;
        wres_d   = wres_q;
        acc_d    = acc_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (lane_op) begin
                        state_d = LANE;
                        lane_d  = 2'd1;
                        acc_d   = acc_next;
                        wres_d  = put_lane(wres_q, 2'd0, prod[23:8]);
                    end else begin
                        // Single-cycle ops are resolved here; DONE is their only busy cycle.
                        state_d  = DONE;
                        result_d = alu_res;
                    end
                end
            end
            LANE: begin
                lane_d = lane_q + 2'd1;
                acc_d  = acc_next;
                wres_d = put_lane(wres_q, lane_q, prod[23:8]);
                if (lane_q == 2'd3) begin
                    if (op_q == OP_LENGTH) begin
                        state_d = SQRT;
                        iter_d  = 4'd15;
                        rad_d   = (|acc_next[33:32]) ? 32'hFFFF_FFFF : acc_next[31:0];
                        rem_d   = '0;
                        root_d  = '0;
                    end else begin
                        state_d  = DONE;
                        result_d = (op_q == OP_DOT) ? {acc_next[23:8], 48'd0}
                                                    : put_lane(wres_q, 2'd3, prod[23:8]);
                    end
                end
            end
            SQRT: begin
                rad_d  = rad_q << 2;
                rem_d  = (rem_sh >= trial) ? (rem_sh - trial) : rem_sh;
                root_d = root_n;
                iter_d = iter_q - 4'd1;
                if (iter_q == 4'd0) begin
                    state_d  = DONE;
                    result_d = {root_n, 48'd0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lane_q   <= '0;
            iter_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            op_q     <= '0;
            wres_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            iter_q   <= iter_d;
            wres_q   <= wres_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            if (idle && start) begin
                a_q  <= vec_a;
                b_q  <= vec_b;
                s_q  <= scalar;
                op_q <= operation;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
endmodule
